// File: rtl/deskew_pkg.sv
// Shared deskew definitions: arbiter state encoding and pixel BRAM geometry.
// Used by the arbiter and by the deskew datapath that drives its requester-0 port.
package deskew_pkg;

    localparam int BRAM_ADDR_W = 17;
    localparam int BRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    function automatic arb_state_t own_state(input logic side);
        return side ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/deskew_rd_tag_pipe.sv
// Read-return tag pipe: carries {valid, tag} for each issued read to its return cycle.
// Latency: exactly DEPTH cycles; no backpressure, one entry accepted and retired every cycle.
module deskew_rd_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_vld,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    output logic [TAG_W-1:0] o_tag
);

    logic             r_vld [DEPTH];
    logic [TAG_W-1:0] r_tag [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
                r_tag[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_tag[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_tag = r_tag[DEPTH-1];

endmodule

// File: rtl/deskew_bram_arbiter.sv
// Two-requester pixel BRAM arbiter with bounded bursts; read data broadcast, rvalid steered to issuer.
// Latency: grant 1 cycle after req in IDLE, 0 while owning; rvalid RD_LATENCY after read; ungranted requests held.
module deskew_bram_arbiter
    import deskew_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_W,
    parameter int DATA_WIDTH = BRAM_DATA_W,
    parameter int MAX_BURST  = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic                  m0_we,
    output logic                  m0_gnt,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic                  m1_we,
    output logic                  m1_gnt,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_rvalid,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pen,
    output logic                  pwen,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_last_owner;
    logic             w_own_side;
    logic             w_req_own;
    logic             w_req_oth;
    logic             w_xfer;
    logic             w_burst_hit;
    logic             w_burst_max;
    logic             w_pipe_vld;
    logic             w_pipe_tag;

    assign w_own_side = (r_state == OWN1);
    assign w_req_own  = w_own_side ? m1_req : m0_req;
    assign w_req_oth  = w_own_side ? m0_req : m1_req;

    assign m0_gnt = (r_state == OWN0) && m0_req;
    assign m1_gnt = (r_state == OWN1) && m1_req;
    assign w_xfer = m0_gnt || m1_gnt;

    assign pen    = w_xfer;
    assign pwen   = m1_gnt ? m1_we    : (m0_gnt ? m0_we    : 1'b0);
    assign paddr  = m1_gnt ? m1_addr  : (m0_gnt ? m0_addr  : '0);
    assign pwdata = m1_gnt ? m1_wdata : (m0_gnt ? m0_wdata : '0);
    assign busy   = (r_state != IDLE);

    // The transfer that brings the count to MAX_BURST (or any once saturated) may yield.
    assign w_burst_hit = (r_burst_cnt >= CNT_W'(MAX_BURST - 1));
    assign w_burst_max = (r_burst_cnt == CNT_W'(MAX_BURST));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    w_state_nxt = r_last_owner ? OWN0 : OWN1;
                end else if (m0_req) begin
                    w_state_nxt = OWN0;
                end else if (m1_req) begin
                    w_state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!w_req_own) begin
                    w_state_nxt = w_req_oth ? own_state(!w_own_side) : IDLE;
                end else if (w_burst_hit && w_req_oth) begin
                    w_state_nxt = own_state(!w_own_side);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_burst_cnt  <= '0;
            r_last_owner <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_burst_cnt <= '0;
                if (r_state != IDLE) begin
                    r_last_owner <= w_own_side;
                end
            end else if (w_xfer && !w_burst_max) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
        end
    end

    deskew_rd_tag_pipe #(
        .DEPTH (RD_LATENCY),
        .TAG_W (1)
    ) u_rd_tag_pipe (
        .clk    (clk),
        .resetn (resetn),
        .i_vld  (w_xfer && !pwen),
        .i_tag  (m1_gnt),
        .o_vld  (w_pipe_vld),
        .o_tag  (w_pipe_tag)
    );

    assign m0_rvalid = w_pipe_vld && !w_pipe_tag;
    assign m1_rvalid = w_pipe_vld &&  w_pipe_tag;

    // Gated so that every output reads 0 while reset is held, whatever the BRAM presents.
    assign m0_rdata = resetn ? prdata : '0;
    assign m1_rdata = resetn ? prdata : '0;

    a_gnt_mutex: assert property (@(posedge clk) disable iff (!resetn)
        !(m0_gnt && m1_gnt));
    a_pen_xfer: assert property (@(posedge clk) disable iff (!resetn)
        pen == ((m0_req && m0_gnt) || (m1_req && m1_gnt)));

endmodule

// File: doc/deskew_bram_arbiter.md
DESKEW_BRAM_ARBITER -- requirements
Module: deskew_bram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 17, pixel BRAM address width; DATA_WIDTH, 8, pixel width; MAX_BURST, 16, maximum back-to-back transfers per ownership while the other side waits; RD_LATENCY, 1, BRAM read latency in cycles.
REQ-002 Clock and reset SHALL be: clk in 1, single clock; resetn in 1, asynchronous active-low reset.
REQ-003 Port m0_req in 1 SHALL request an access from requester 0, the deskew datapath.
REQ-004 Requester 0 transfer ports SHALL be: m0_addr in ADDR_WIDTH; m0_wdata in DATA_WIDTH; m0_we in 1, where 1 = write and 0 = read.
REQ-005 Requester 0 return ports SHALL be: m0_gnt out 1, transfer accepted this cycle; m0_rdata out DATA_WIDTH; m0_rvalid out 1, m0_rdata valid.
REQ-006 Requester 1, the host image loader, SHALL have ports m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rdata and m1_rvalid, identical to requester 0.
REQ-007 BRAM-side outputs SHALL be: paddr out ADDR_WIDTH; pwdata out DATA_WIDTH; pen out 1; pwen out 1.
REQ-008 Port prdata in DATA_WIDTH SHALL carry BRAM read data.
REQ-009 Port busy out 1 SHALL be 1 whenever the state is not IDLE.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, OWN0 and OWN1, registered on clk.
REQ-011 Grant SHALL follow mX_gnt = (state==OWNX) && mX_req; a transfer occurs on every cycle where req && gnt are both 1.
REQ-012 On a transfer, pen SHALL be 1, pwen SHALL equal the owner's we, and paddr/pwdata SHALL be the owner's addr/wdata, all combinationally in the same cycle.
REQ-013 With no transfer, pen, pwen, paddr and pwdata SHALL all be 0.
REQ-014 In IDLE with only mX_req set, the next state SHALL be OWNX.
REQ-015 In IDLE with both requests set, the next state SHALL be the side not flagged by last_owner; last_owner resets to 1, so requester 0 wins first.
REQ-016 In OWNX with mX_req low, the next state SHALL be OWN(other) if the other requester is requesting, else IDLE.
REQ-017 burst_cnt SHALL clear on entry to an OWN state and increment on each transfer, saturating at MAX_BURST.
REQ-018 In OWNX, when the transfer that makes burst_cnt equal MAX_BURST occurs and the other requester is requesting, the next state SHALL be OWN(other); otherwise ownership continues.
REQ-019 last_owner SHALL update on every OWN-state exit.
REQ-020 Grant latency SHALL be 1 cycle from a req rising in IDLE, and 0 cycles once the requester owns the port.
REQ-021 Handoff between owners SHALL take no idle cycle.
REQ-022 A requester SHALL hold addr/we/wdata stable while req=1 and gnt=0; the arbiter never drops an ungranted request.
REQ-023 Read return SHALL use an RD_LATENCY-deep shift register of {valid, owner}, loaded on each read transfer (pen=1, pwen=0).
REQ-024 m0_rdata and m1_rdata SHALL both equal prdata (broadcast).
REQ-025 mX_rvalid SHALL be 1 exactly RD_LATENCY cycles after a read transfer by X.
REQ-026 Writes SHALL produce no rvalid.
REQ-027 Reads issued before a handoff SHALL still be returned to their issuer after the handoff.
REQ-028 Simultaneous req rise on both sides in IDLE SHALL resolve per REQ-015, with exactly one grant per cycle.
REQ-029 m0_gnt && m1_gnt SHALL never be 1 in the same cycle.

Reset
REQ-030 Asserting resetn low SHALL force state=IDLE, burst_cnt=0, last_owner=1 and the read shift register all-invalid, asynchronously.
REQ-031 During reset, all outputs SHALL be 0.
REQ-032 Reset asserted mid-burst SHALL discard in-flight reads, with no rvalid after deassertion.
REQ-033 The first grant SHALL be possible 1 cycle after resetn deasserts.

Structure
REQ-034 A shared deskew package SHALL hold the state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and the BRAM width constants shared with the datapath.
REQ-035 The read-return shift register SHALL be a sub-module, deskew_rd_tag_pipe, parameterised by depth and tag width.
REQ-036 deskew_bram_arbiter SHALL sit between the datapath BRAM port and the top-level paddr/pwdata/prdata/pen/pwen pins.

Verification
REQ-037 Single requester, read: m0_req=1, m0_we=0, m0_addr=17'h00010 from IDLE -> m0_gnt=1 next cycle, paddr=17'h00010, pen=1, pwen=0; m0_rvalid=1 one cycle later with m0_rdata=prdata.
REQ-038 Simultaneous requests after reset: m0_req=m1_req=1 continuously -> OWN0 for 16 transfers, then OWN1 for 16 transfers with no gap cycle, then OWN0 again.
REQ-039 Release handoff: m1 owns, m0 waiting, m1_req drops after 3 writes -> m0_gnt=1 the next cycle, with pwen following m0_we.
REQ-040 Reads across handoff: m0 issues a read to 17'h1FFFF on the last burst slot, m1 granted next cycle -> m0_rvalid=1 and m1_rvalid=0 in that cycle.
REQ-041 Reset mid-burst: resetn low for 2 cycles during an m1 read burst -> all outputs 0, no rvalid after release, first grant goes to m0 when both request.
REQ-042 A concurrent assertion SHALL check mutual exclusion of m0_gnt/m1_gnt and that pen==(m0_req&&m0_gnt || m1_req&&m1_gnt) on every cycle.
